// File: rtl/simon_pkg.sv
// Shared constants, types and helpers for the iterative SIMON32/64 core.
//   WORD_W/BLOCK_W/KEY_W : datapath widths
//   ROUNDS               : round count for SIMON32/64
//   Z0                   : z0 constant sequence, bit i = symbol i
//   C_CONST              : ~3 in 16 bits; kw0 ^ C_CONST == ~kw0 ^ 3
//   state_e              : controller state encoding
package simon_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BLOCK_W = 32;
  localparam int unsigned KEY_W   = 64;
  localparam int unsigned ROUNDS  = 32;
  localparam int unsigned RND_W   = 5;

  // Two copies of the period-31 z0 pattern, written MSB first so that
  // Z0[0] is the first symbol of the sequence.
  localparam logic [61:0] Z0 =
    62'b0110011100001101010010001011111_0110011100001101010010001011111;

  localparam logic [WORD_W-1:0] C_CONST = 16'hFFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v,
                                            input int unsigned        s);
    return (v << s) | (v >> (WORD_W - s));
  endfunction

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v,
                                            input int unsigned        s);
    return (v >> s) | (v << (WORD_W - s));
  endfunction

endpackage

// File: rtl/round_function.sv
// One combinational SIMON32 Feistel round.
//   state_in     : {x, y} before the round
//   round_key    : round key k
//   state_next_c : {f(x) ^ y ^ k, x}
module round_function
  import simon_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_in,
  input  logic [WORD_W-1:0]  round_key,
  output logic [BLOCK_W-1:0] state_next_c
);

  logic [WORD_W-1:0] x;
  logic [WORD_W-1:0] y;
  logic [WORD_W-1:0] left_c;

  assign x = state_in[BLOCK_W-1:WORD_W];
  assign y = state_in[WORD_W-1:0];

  // f(x) = (x<<<1 & x<<<8) ^ x<<<2
  assign left_c = (rol(x, 1) & rol(x, 8)) ^ y ^ rol(x, 2) ^ round_key;

  assign state_next_c = {left_c, x};

endmodule

// File: rtl/simon_enc_ctrl.sv
// Iterative SIMON32/64 encryption sequencer: one round per clock, round
// keys generated on the fly by a four-word shift register.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : plaintext + key handshake (ready only in IDLE)
//   plaintext             : {x, y}
//   key                   : {k3, k2, k1, k0}, k0 used in the first round
//   out_valid/out_ready   : ciphertext handshake (valid only in DONE)
//   ciphertext            : current block state, qualified by out_valid
//   busy                  : high in RUN or DONE
module simon_enc_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned ROUNDS = simon_pkg::ROUNDS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLOCK_W-1:0]  plaintext,
  input  logic [KEY_W-1:0]    key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  ciphertext,
  output logic                busy
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  state_e             state;
  state_e             state_nxt;
  logic               load;
  logic               step;

  logic [BLOCK_W-1:0] state_reg;
  logic [BLOCK_W-1:0] round_out_c;
  logic [WORD_W-1:0]  kw0, kw1, kw2, kw3;
  logic [RND_W-1:0]   rnd;

  logic [WORD_W-1:0]  tmp_a;
  logic [WORD_W-1:0]  tmp_b;
  logic [WORD_W-1:0]  new_key;

  round_function u_round (
    .state_in     (state_reg),
    .round_key    (kw0),
    .state_next_c (round_out_c)
  );

  // Next key word; ~kw0 ^ 3 folded into kw0 ^ C_CONST.
  always_comb begin
    tmp_a   = ror(kw3, 3) ^ kw1;
    tmp_b   = tmp_a ^ ror(tmp_a, 1);
    new_key = kw0 ^ C_CONST ^ tmp_b ^ {15'b0, Z0[6'(rnd)]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath enables.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (rnd == LAST_RND) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Block state, key schedule and round counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      kw0       <= '0;
      kw1       <= '0;
      kw2       <= '0;
      kw3       <= '0;
      rnd       <= '0;
    end else if (load) begin
      state_reg <= plaintext;
      kw0       <= key[15:0];
      kw1       <= key[31:16];
      kw2       <= key[47:32];
      kw3       <= key[63:48];
      rnd       <= '0;
    end else if (step) begin
      state_reg <= round_out_c;
      kw0       <= kw1;
      kw1       <= kw2;
      kw2       <= kw3;
      kw3       <= new_key;
      rnd       <= rnd + RND_W'(1);
    end
  end

  // Handshake flags registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
    end
  end

  assign ciphertext = state_reg;

endmodule

// File: tb/tb_simon_enc_ctrl.sv
// Directed self-checking bench for simon_enc_ctrl.
module tb_simon_enc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] plaintext;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ciphertext;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [31:0] KAT_CT  = 32'hC69B_E9BB;

  simon_enc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model, written from the published algorithm.
  function automatic logic [15:0] m_rol(input logic [15:0] v, input int unsigned s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] m_ror(input logic [15:0] v, input int unsigned s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic m_z0(input int unsigned j);
    string zs;
    zs = "1111101000100101011000011100110";
    return zs[j % 31] == 8'h31;
  endfunction

  function automatic logic [15:0] m_rk(input logic [63:0] k, input int unsigned i);
    logic [15:0] w0, w1, w2, w3, t, nk;
    w0 = k[15:0]; w1 = k[31:16]; w2 = k[47:32]; w3 = k[63:48];
    for (int unsigned j = 0; j < i; j++) begin
      t  = m_ror(w3, 3) ^ w1;
      t  = t ^ m_ror(t, 1);
      nk = ~w0 ^ t ^ {15'b0, m_z0(j)} ^ 16'h0003;
      w0 = w1; w1 = w2; w2 = w3; w3 = nk;
    end
    return w0;
  endfunction

  function automatic logic [31:0] m_enc(input logic [31:0] pt, input logic [63:0] k);
    logic [15:0] x, y, t;
    x = pt[31:16]; y = pt[15:0];
    for (int unsigned r = 0; r < 32; r++) begin
      t = (m_rol(x, 1) & m_rol(x, 8)) ^ y ^ m_rol(x, 2) ^ m_rk(k, r);
      y = x;
      x = t;
    end
    return {x, y};
  endfunction

  // Offer a block and return #1 after the accepting edge.
  task automatic do_accept(input logic [31:0] pt, input logic [63:0] k);
    int guard;
    guard = 0;
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge (inclusive) to the first out_valid cycle.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  initial begin
    int          cyc;
    int          c, na, no;
    int          acc [3];
    logic [31:0] pts [3];
    logic [63:0] rkey;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; key = '0;
    #2;
    check("rst_in_ready",  64'(in_ready),   64'd1);
    check("rst_out_valid", 64'(out_valid),  64'd0);
    check("rst_busy",      64'(busy),       64'd0);
    check("rst_ct",        64'(ciphertext), 64'd0);
    check("rst_rnd",       64'(dut.rnd),    64'd0);
    check("rst_kw0",       64'(dut.kw0),    64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // KAT with latency, an ignored in_valid pulse at rnd 5, and back-pressure.
    do_accept(KAT_PT, KAT_KEY);
    check("run_busy", 64'(busy), 64'd1);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      if (cyc == 6) begin
        check("ign_rnd", 64'(dut.rnd), 64'd5);
        check("ign_in_ready", 64'(in_ready), 64'd0);
        plaintext = 32'hDEAD_BEEF;
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("kat_latency", 64'(cyc), 64'd33);
    check("kat_ct", 64'(ciphertext), 64'(KAT_CT));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid",    64'(out_valid),  64'd1);
      check("bp_ct",       64'(ciphertext), 64'(KAT_CT));
      check("bp_in_ready", 64'(in_ready),   64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_valid",    64'(out_valid), 64'd0);
    check("hs_in_ready", 64'(in_ready),  64'd1);
    check("hs_busy",     64'(busy),      64'd0);

    // Reset in the middle of a run.
    do_accept(KAT_PT, 64'h0123_4567_89AB_CDEF);
    repeat (12) @(posedge clk);
    #1;
    check("mid_rnd", 64'(dut.rnd), 64'd12);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid),  64'd0);
    check("mid_rst_ready", 64'(in_ready),   64'd1);
    check("mid_rst_busy",  64'(busy),       64'd0);
    check("mid_rst_ct",    64'(ciphertext), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    do_accept(KAT_PT, KAT_KEY);
    wait_valid(cyc);
    check("kat2_latency", 64'(cyc), 64'd33);
    check("kat2_ct", 64'(ciphertext), 64'(KAT_CT));
    @(posedge clk); #1;
    check("kat2_done", 64'(out_valid), 64'd0);

    // Back-to-back blocks with in_valid and out_ready held high.
    pts[0] = 32'h0000_0000;
    pts[1] = 32'hFFFF_FFFF;
    pts[2] = 32'h1234_ABCD;
    c = 0; na = 0; no = 0;
    plaintext = pts[0];
    key       = KAT_KEY;
    in_valid  = 1'b1;
    while (no < 3 && c < 300) begin
      if (in_valid && in_ready) begin
        acc[na] = c;
        na++;
      end
      if (out_valid) begin
        check("b2b_ct", 64'(ciphertext), 64'(m_enc(pts[no], KAT_KEY)));
        no++;
      end
      @(posedge clk); #1;
      c++;
      if (na < 3) plaintext = pts[na];
      else        in_valid  = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_outputs", 64'(no), 64'd3);
    check("b2b_accepts", 64'(na), 64'd3);
    if (na == 3) begin
      check("b2b_ii_01", 64'(acc[1] - acc[0]), 64'd34);
      check("b2b_ii_12", 64'(acc[2] - acc[1]), 64'd34);
    end

    // Round keys observed each RUN cycle against the software schedule.
    @(posedge clk); #1;
    rkey = {$urandom, $urandom};
    do_accept(32'hA5A5_5A5A, rkey);
    for (int unsigned i = 0; i < 32; i++) begin
      check("round_key", 64'(dut.kw0), 64'(m_rk(rkey, i)));
      @(posedge clk); #1;
    end
    check("rk_valid", 64'(out_valid), 64'd1);
    check("rk_ct", 64'(ciphertext), 64'(m_enc(32'hA5A5_5A5A, rkey)));
    @(posedge clk); #1;
    check("rk_idle", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
